counter_seq_ctrl: RTL and testbench
===================================

// Module: counter_seq_ctrl
// PURPOSE
//   Sequencing controller for the team's 4-bit up-counter datapath: turns it into a programmable timer.
//   Owns config registers (terminal value, prescale, mode) and an FSM that starts, holds, stops and restarts counting.
//   Emits done/wrap pulses to the surrounding logic. Sits between the CPU-side control strobes and the counter core.
// PARAMETERS
//   WIDTH       4   counter / terminal-value width in bits
//   PRESCALE_W  4   prescaler width in bits; tick period = cfg_prescale+1 clk cycles
// PORTS
//   clk           in   1            clock, all state on rising edge
//   reset         in   1            asynchronous, active-high; clock clk
//   cfg_we        in   1            write cfg_* into config regs (accepted only in IDLE or DONE)
//   cfg_limit     in   WIDTH        terminal count value
//   cfg_prescale  in   PRESCALE_W   prescale divisor minus one
//   cfg_periodic  in   1            1 = auto-reload and keep running, 0 = one-shot
//   start         in   1            pulse: clear and begin counting
//   stop          in   1            pulse: abort, return to IDLE
//   hold          in   1            level: freeze count and prescaler while high
//   count         out  WIDTH        current count value
//   state         out  2            FSM state encoding
//   busy          out  1            high in RUN or HOLD
//   done          out  1            one-cycle pulse on one-shot completion
//   wrap          out  1            one-cycle pulse on periodic reload
// BEHAVIOUR
//   Reset: state=IDLE(00), count=0, prescaler=0, busy=0, done=0, wrap=0, cfg_limit_r=all-ones, cfg_prescale_r=0, cfg_periodic_r=0.
//   States: IDLE=00, RUN=01, HOLD=10, DONE=11. All outputs registered.
//   Priority per cycle: stop > start > hold > tick.
//   stop (any state): -> IDLE, count=0, prescaler=0 next edge.
//   start (any state, no stop): -> RUN, count=0, prescaler=0; restart if already RUN/HOLD.
//   cfg_we: config regs load on the edge only when state is IDLE or DONE; ignored in RUN/HOLD (no error flag).
//     cfg_we and start same cycle: new config applies to that run.
//   RUN, hold=1: -> HOLD, count/prescaler frozen. HOLD, hold=0: -> RUN, resume from frozen values.
//   Tick: in RUN, prescaler counts 0..cfg_prescale_r; tick when prescaler==cfg_prescale_r (prescaler returns to 0).
//   Tick with count!=limit: count+1. First increment occurs cfg_prescale_r+1 cycles after start edge.
//   Tick with count==limit: one-shot -> DONE, count holds limit, done=1 one cycle;
//     periodic -> count=0, wrap=1 one cycle, stay RUN. Period = (limit+1)*(prescale+1) cycles.
//   limit=0: every tick is terminal. limit=2^WIDTH-1: natural wrap, no overflow beyond WIDTH.
//   DONE: count held, busy=0; waits for start, stop or cfg_we. done not re-asserted.
//   Reset mid-run: immediate async return to reset values; config lost.
// CONFIGURATION
//   COUNTER_SEQ_DOWN_EN defined: adds input cfg_down (1 bit, latched with cfg_we);
//     when 1, start loads count=cfg_limit_r, ticks decrement, terminal at count==0 (reload = limit).
//   Undefined: cfg_down port absent, up-count only as above.
// STRUCTURE
//   Shared header counter_seq_defs.vh: state encodings (ST_IDLE/ST_RUN/ST_HOLD/ST_DONE), reset defaults for config regs.
//   One sub-module counter_seq_core: WIDTH-bit counter with clr, en, load, load_val (and dir under COUNTER_SEQ_DOWN_EN),
//     terminal-compare output; the FSM, prescaler and config regs stay in counter_seq_ctrl.
// TESTING
//   1 reset mid-RUN at count=5 -> count=0, state=00, busy=0 within same cycle, config back to defaults.
//   2 cfg limit=3, prescale=0, one-shot, start -> count 0,1,2,3 on consecutive cycles, done pulse 1 cycle, state=11, count holds 3.
//   3 limit=2, prescale=2, periodic -> count steps every 3 cycles, wrap pulse every 9 cycles, state stays 01.
//   4 hold high 4 cycles at count=1 -> count/prescaler frozen, state=10; release -> resumes, total period +4.
//   5 stop and start same cycle during RUN -> state=00, count=0; cfg_we during RUN with limit=7 -> limit unchanged.
//   6 limit=15, prescale=0, periodic -> wrap from 15 to 0 after 16 cycles; with COUNTER_SEQ_DOWN_EN, cfg_down=1, limit=3 -> 3,2,1,0,3.

Source files
------------

// File: rtl/counter_seq_ctrl_pkg.sv
// counter_seq_ctrl_pkg: shared definitions for the counter sequencing controller.
//   - state_t    : FSM state encodings (IDLE=00, RUN=01, HOLD=10, DONE=11)
//   - reset defaults for the config registers
//   - is_active  : true for the states in which the counter is owned by a run
// Optional feature macro used by this block: COUNTER_SEQ_DOWN_EN (down-count mode).
package counter_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_t;

  // Config register reset values. The terminal value resets to all-ones,
  // which is width dependent, so it is applied as '1 at the register.
  localparam logic CFG_PERIODIC_RST = 1'b0;
  localparam logic CFG_DOWN_RST     = 1'b0;

  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/counter_seq_core.sv
// counter_seq_core: WIDTH-bit counter datapath with terminal compare.
// Ports:
//   clk, reset      clock / asynchronous active-high reset
//   clr             force count to 0 (highest priority)
//   load, load_val  load count with load_val
//   en              step the counter by one
//   dir             (COUNTER_SEQ_DOWN_EN only) 1 = count down
//   term_val        terminal value for up counting
//   count           registered count
//   terminal        count is at its terminal value (term_val up, 0 down)
import counter_seq_ctrl_pkg::*;

module counter_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_SEQ_DOWN_EN
  input  logic             dir,
`endif
  input  logic [WIDTH-1:0] term_val,
  output logic [WIDTH-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clr)   count <= '0;
    else if (load)  count <= load_val;
    else if (en) begin
`ifdef COUNTER_SEQ_DOWN_EN
      count <= dir ? count - 1'b1 : count + 1'b1;
`else
      count <= count + 1'b1;
`endif
    end
  end

`ifdef COUNTER_SEQ_DOWN_EN
  assign terminal = dir ? (count == '0) : (count == term_val);
`else
  assign terminal = (count == term_val);
`endif

endmodule

// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: programmable timer built around counter_seq_core.
// Owns the config registers, the prescaler and the run/hold/done FSM.
// Optional feature macro: COUNTER_SEQ_DOWN_EN adds cfg_down (down-count mode).
// Ports:
//   clk, reset     clock / asynchronous active-high reset
//   cfg_we         load cfg_* (honoured only in IDLE or DONE)
//   cfg_limit      terminal count value
//   cfg_prescale   tick period minus one
//   cfg_periodic   1 = auto-reload, 0 = one-shot
//   cfg_down       (COUNTER_SEQ_DOWN_EN only) 1 = count down from limit
//   start, stop    control pulses (stop wins)
//   hold           level: freeze count and prescaler
//   count, state   current count / FSM state
//   busy           RUN or HOLD
//   done, wrap     one-cycle completion / reload pulses
import counter_seq_ctrl_pkg::*;

module counter_seq_ctrl #(
  parameter int WIDTH      = 4,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [WIDTH-1:0]      cfg_limit,
  input  logic [PRESCALE_W-1:0] cfg_prescale,
  input  logic                  cfg_periodic,
`ifdef COUNTER_SEQ_DOWN_EN
  input  logic                  cfg_down,
`endif
  input  logic                  start,
  input  logic                  stop,
  input  logic                  hold,
  output logic [WIDTH-1:0]      count,
  output logic [1:0]            state,
  output logic                  busy,
  output logic                  done,
  output logic                  wrap
);

  state_t                st;
  logic [PRESCALE_W-1:0] psc;
  logic [WIDTH-1:0]      cfg_limit_r;
  logic [PRESCALE_W-1:0] cfg_prescale_r;
  logic                  cfg_periodic_r;

  logic             cfg_load, running, tick, term;
  logic [WIDTH-1:0] lim_eff;
  logic             core_clr, core_load, core_en;

  // Config is only writable while no run owns the counter. A write in the
  // same cycle as start must already steer that start, hence lim_eff.
  assign cfg_load = cfg_we && ((st == ST_IDLE) || (st == ST_DONE));
  assign lim_eff  = cfg_load ? cfg_limit : cfg_limit_r;
  assign running  = is_active(st);
  // HOLD with hold released advances immediately, so a hold of N cycles
  // stretches the period by exactly N.
  assign tick     = running && !hold && (psc == cfg_prescale_r);

`ifdef COUNTER_SEQ_DOWN_EN
  logic cfg_down_r, down_eff;
  assign down_eff = cfg_load ? cfg_down : cfg_down_r;
`endif

  always_comb begin
    core_clr  = 1'b0;
    core_load = 1'b0;
    core_en   = 1'b0;
    if (stop) begin
      core_clr = 1'b1;
    end else if (start) begin
`ifdef COUNTER_SEQ_DOWN_EN
      if (down_eff) core_load = 1'b1;
      else          core_clr  = 1'b1;
`else
      core_clr = 1'b1;
`endif
    end else if (tick) begin
      if (!term) begin
        core_en = 1'b1;
      end else if (cfg_periodic_r) begin
`ifdef COUNTER_SEQ_DOWN_EN
        if (cfg_down_r) core_load = 1'b1;
        else            core_clr  = 1'b1;
`else
        core_clr = 1'b1;
`endif
      end
      // one-shot terminal: count simply holds
    end
  end

  counter_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .clr      (core_clr),
    .en       (core_en),
    .load     (core_load),
    .load_val (lim_eff),
`ifdef COUNTER_SEQ_DOWN_EN
    .dir      (cfg_down_r),
`endif
    .term_val (cfg_limit_r),
    .count    (count),
    .terminal (term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st             <= ST_IDLE;
      psc            <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      wrap           <= 1'b0;
      cfg_limit_r    <= '1;
      cfg_prescale_r <= '0;
      cfg_periodic_r <= CFG_PERIODIC_RST;
`ifdef COUNTER_SEQ_DOWN_EN
      cfg_down_r     <= CFG_DOWN_RST;
`endif
    end else begin
      done <= 1'b0;
      wrap <= 1'b0;
      if (cfg_load) begin
        cfg_limit_r    <= cfg_limit;
        cfg_prescale_r <= cfg_prescale;
        cfg_periodic_r <= cfg_periodic;
`ifdef COUNTER_SEQ_DOWN_EN
        cfg_down_r     <= cfg_down;
`endif
      end
      if (stop) begin
        st   <= ST_IDLE;
        psc  <= '0;
        busy <= 1'b0;
      end else if (start) begin
        st   <= ST_RUN;
        psc  <= '0;
        busy <= 1'b1;
      end else if (running) begin
        if (hold) begin
          st <= ST_HOLD;
        end else if (psc == cfg_prescale_r) begin
          psc <= '0;
          st  <= ST_RUN;
          if (term && cfg_periodic_r) begin
            wrap <= 1'b1;
          end else if (term) begin
            st   <= ST_DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end
        end else begin
          psc <= psc + 1'b1;
          st  <= ST_RUN;
        end
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb_counter_seq_ctrl: directed scenarios plus randomized traffic, checked
// every cycle against a reference model that derives the count from the
// number of advancing cycles since start (tick index modulo limit+1).
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       cfg_we, cfg_periodic, cfg_down, start, stop, hold;
  logic [3:0] cfg_limit, cfg_prescale;
  logic [3:0] count;
  logic [1:0] state;
  logic       busy, done, wrap;

  int n_chk = 0;
  int n_err = 0;

  // reference model
  int m_st, m_cnt, m_e, m_lim, m_psc, m_per, m_down, m_done, m_wrap;

  always #5 clk = ~clk;

  counter_seq_ctrl #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_we       (cfg_we),
    .cfg_limit    (cfg_limit),
    .cfg_prescale (cfg_prescale),
    .cfg_periodic (cfg_periodic),
`ifdef COUNTER_SEQ_DOWN_EN
    .cfg_down     (cfg_down),
`endif
    .start        (start),
    .stop         (stop),
    .hold         (hold),
    .count        (count),
    .state        (state),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_e = 0; m_done = 0; m_wrap = 0;
    m_lim = 15; m_psc = 0; m_per = 0; m_down = 0;
  endtask

  // One rising edge of the specified behaviour, using the current inputs.
  task automatic model_step();
    int k;
    m_done = 0;
    m_wrap = 0;
    if (cfg_we && (m_st == 0 || m_st == 3)) begin
      m_lim = int'(cfg_limit);
      m_psc = int'(cfg_prescale);
      m_per = int'(cfg_periodic);
`ifdef COUNTER_SEQ_DOWN_EN
      m_down = int'(cfg_down);
`else
      m_down = 0;
`endif
    end
    if (stop) begin
      m_st = 0; m_e = 0; m_cnt = 0;
    end else if (start) begin
      m_st = 1; m_e = 0;
    end else if (m_st == 1 || m_st == 2) begin
      if (hold) m_st = 2;
      else begin
        m_st = 1;
        m_e++;
        if (m_e % (m_psc + 1) == 0 && (m_e / (m_psc + 1)) % (m_lim + 1) == 0) begin
          if (m_per != 0) m_wrap = 1;
          else begin
            m_st = 3; m_done = 1;
            m_cnt = m_down ? 0 : m_lim;
          end
        end
      end
    end
    if (m_st == 1 || m_st == 2) begin
      k = (m_e / (m_psc + 1)) % (m_lim + 1);
      m_cnt = m_down ? m_lim - k : k;
    end
  endtask

  task automatic check_outputs();
    chk("count", int'(count), m_cnt);
    chk("state", int'(state), m_st);
    chk("busy",  int'(busy),  (m_st == 1 || m_st == 2) ? 1 : 0);
    chk("done",  int'(done),  m_done);
    chk("wrap",  int'(wrap),  m_wrap);
  endtask

  // Called at a falling edge: drive, clock, model, check.
  task automatic cyc(input logic we, input logic [3:0] lim, input logic [3:0] psc,
                     input logic per, input logic dn, input logic st,
                     input logic sp, input logic hd);
    cfg_we = we; cfg_limit = lim; cfg_prescale = psc; cfg_periodic = per;
    cfg_down = dn; start = st; stop = sp; hold = hd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  int hold_left;

  initial begin
    reset = 1'b1;
    cfg_we = 0; cfg_limit = 0; cfg_prescale = 0; cfg_periodic = 0;
    cfg_down = 0; start = 0; stop = 0; hold = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset = 1'b0;
    idle(2);

    // reset mid-run at count 5, then defaults must be back
    cyc(1'b1, 4'd9, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(5);
    chk("pre_reset_count", int'(count), 5);
    #2 reset = 1'b1;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_busy",  int'(busy),  0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // default: limit 15, one-shot
    idle(18);
    chk("default_done_count", int'(count), 15);

    // one-shot limit 3, prescale 0
    cyc(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(6);
    chk("oneshot_hold_state", int'(state), 3);

    // periodic limit 2, prescale 2
    cyc(1'b1, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);

    // hold 4 cycles at count 1 (stop first to make config writable)
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 4'd3, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(10);

    // stop+start together during RUN; cfg_we ignored during RUN
    cyc(1'b1, 4'd4, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("stop_start_state", int'(state), 0);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(8);
    chk("cfg_ignored_count", int'(count), 4);

    // natural wrap at limit 15
    cyc(1'b1, 4'd15, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(34);
`ifdef COUNTER_SEQ_DOWN_EN
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 4'd3, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(10);
    cyc(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // randomized traffic with bursty hold
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 9) == 0) hold_left = $urandom_range(1, 5);
      cyc(($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 24) == 0), ($urandom_range(0, 59) == 0), (hold_left > 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
